mod_count_checker: RTL and testbench

- Receive-side monitor for the synchronous mod-N counter's `count` bus.
- Samples the counter output every enabled cycle and acquires lock on the sequence 0,1,…,MODULUS-1,0,…
- Once locked, flags skipped, stuck or out-of-range values and reports wrap events.
- Sits beside the counter in the top level and feeds the status/debug logic.

---
 rtl/mod_count_checker_pkg.sv | 19 +
 rtl/mod_count_checker_if.sv | 27 ++
 rtl/mod_count_checker_sat_counter.sv | 20 ++
 rtl/mod_count_checker.sv | 116 +++++++++++
 tb/tb_mod_count_checker.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_count_checker_pkg.sv
// Shared definitions for the mod-N count checker: FSM state encoding and
// the modulo-increment helper used to predict the next counter value.
package mod_count_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Value the counter should show after 'value' for a mod-'modulus' counter.
  // A true modulo is used so an out-of-range previous sample still yields
  // a legal prediction.
  function automatic int unsigned next_mod(input int unsigned value,
                                           input int unsigned modulus);
    return (value + 1) % modulus;
  endfunction

endpackage

// File: rtl/mod_count_checker_if.sv
// Bundle between the observed counter side and the checker.
// Handshake: there is no back-pressure. count_in is sampled on a rising clk
// edge only when en=1 (en acts as a valid with an always-ready receiver);
// every status output is registered and reflects the sample of the previous
// enabled edge.
interface mod_count_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 en;
  logic [WIDTH-1:0]     count_in;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 wrap_pulse;
  logic [WIDTH-1:0]     last_good;

  modport master (
    output en, count_in,
    input  locked, err_pulse, err_count, wrap_pulse, last_good
  );

  modport slave (
    input  en, count_in,
    output locked, err_pulse, err_count, wrap_pulse, last_good
  );
endinterface

// File: rtl/mod_count_checker_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Increment on request unless already at the ceiling.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mod_count_checker.sv
// Receive-side monitor for a mod-N counter. Seeds on the first enabled
// sample, acquires lock after LOCK_COUNT consecutive correct increments,
// then flags any skipped, stuck or out-of-range value and reports wraps.
module mod_count_checker
  import mod_count_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MODULUS    = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  mod_count_if.slave bus,
  output state_t     state
);

  localparam int STREAK_W = $clog2(LOCK_COUNT + 1);

  logic [WIDTH-1:0]     prev;
  logic [STREAK_W-1:0]  streak;
  logic                 locked_q;
  logic                 err_pulse_q;
  logic                 wrap_pulse_q;
  logic [WIDTH-1:0]     last_good_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic [WIDTH:0]       expected;
  logic                 good;
  logic                 in_range;
  logic                 is_wrap;
  logic                 err_inc;

  // Prediction is done one bit wider so MODULUS == 2**WIDTH compares cleanly
  // and any count_in >= MODULUS can never match.
  assign expected = (WIDTH+1)'(next_mod(32'(prev), 32'(MODULUS)));
  assign good     = ({1'b0, bus.count_in} == expected);
  assign in_range = ({1'b0, bus.count_in} < (WIDTH+1)'(MODULUS));
  assign is_wrap  = (prev == WIDTH'(MODULUS - 1)) && (bus.count_in == '0);
  assign err_inc  = bus.en && (state == LOCKED) && !good;

  // Lock FSM with registered status outputs; every enabled sample becomes
  // the new reference for the following prediction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prev         <= '0;
      streak       <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      last_good_q  <= '0;
    end else begin
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      if (bus.en) begin
        prev <= bus.count_in;
        case (state)
          IDLE: begin
            state  <= ACQUIRE;
            streak <= '0;
            if (in_range) begin
              last_good_q <= bus.count_in;
            end
          end
          ACQUIRE: begin
            if (good) begin
              last_good_q <= bus.count_in;
              if (streak == STREAK_W'(LOCK_COUNT - 1)) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                streak   <= '0;
              end else begin
                streak <= streak + 1'b1;
              end
            end else begin
              streak <= '0;
            end
          end
          LOCKED: begin
            if (good) begin
              last_good_q  <= bus.count_in;
              wrap_pulse_q <= is_wrap;
            end else begin
              err_pulse_q <= 1'b1;
              state       <= ACQUIRE;
              locked_q    <= 1'b0;
              streak      <= '0;
            end
          end
          default: begin
            state    <= IDLE;
            locked_q <= 1'b0;
            streak   <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .q   (err_count_q)
  );

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.last_good  = last_good_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_mod_count_checker.sv
// Bench for mod_count_checker: two instances (8-bit and 2-bit error counter)
// receive identical stimulus and are compared every sampled cycle against a
// sequence-rule reference model.
module tb_mod_count_checker;
  import mod_count_pkg::*;

  localparam int M = 4;
  localparam int L = 4;

  logic clk;
  logic rst;

  mod_count_if #(.WIDTH(4), .ERR_CNT_W(8)) if_a ();
  mod_count_if #(.WIDTH(4), .ERR_CNT_W(2)) if_b ();
  state_t st_a;
  state_t st_b;

  mod_count_checker #(.WIDTH(4), .MODULUS(M), .LOCK_COUNT(L), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .state(st_a)
  );
  mod_count_checker #(.WIDTH(4), .MODULUS(M), .LOCK_COUNT(L), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .state(st_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state of the observed sequence as the spec describes it
  bit m_seeded, m_locked, m_errp, m_wrap;
  int m_prev, m_run, m_errs, m_lg;

  logic [16:0] obs_a;
  logic [10:0] obs_b;
  assign obs_a = {st_a, if_a.locked, if_a.err_pulse, if_a.wrap_pulse, if_a.last_good, if_a.err_count};
  assign obs_b = {st_b, if_b.locked, if_b.err_pulse, if_b.wrap_pulse, if_b.last_good, if_b.err_count};

  function automatic logic [1:0] exp_state();
    if (!m_seeded) return 2'd0;
    else if (m_locked) return 2'd2;
    else return 2'd1;
  endfunction

  function automatic logic [16:0] exp_a();
    return {exp_state(), m_locked, m_errp, m_wrap, 4'(m_lg), 8'((m_errs > 255) ? 255 : m_errs)};
  endfunction

  function automatic logic [10:0] exp_b();
    return {exp_state(), m_locked, m_errp, m_wrap, 4'(m_lg), 2'((m_errs > 3) ? 3 : m_errs)};
  endfunction

  task automatic model_reset();
    m_seeded = 0; m_locked = 0; m_errp = 0; m_wrap = 0;
    m_prev = 0; m_run = 0; m_errs = 0; m_lg = 0;
  endtask

  task automatic model_step(input bit e, input int v);
    bit ok;
    m_errp = 0;
    m_wrap = 0;
    if (!e) return;
    if (!m_seeded) begin
      m_seeded = 1;
      m_run = 0;
      if (v < M) m_lg = v;
    end else begin
      ok = (v == (m_prev + 1) % M);
      if (!m_locked) begin
        if (ok) begin
          m_run++;
          m_lg = v;
          if (m_run == L) begin m_locked = 1; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end else if (ok) begin
        m_lg = v;
        m_wrap = (m_prev == M - 1) && (v == 0);
      end else begin
        m_errp = 1;
        m_errs++;
        m_locked = 0;
        m_run = 0;
      end
    end
    m_prev = v;
  endtask

  // Driver tasks
  task automatic cycle(input bit e, input int v);
    @(negedge clk);
    if_a.en = e; if_a.count_in = 4'(v);
    if_b.en = e; if_b.count_in = 4'(v);
    @(posedge clk);
    model_step(e, v);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    if_a.en = 1'b0; if_b.en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    do_reset(2);
    n_checks++;
    if (obs_a !== 17'd0) begin n_errors++; $display("FAIL reset_a: got %h expected %h", obs_a, 17'd0); end
    n_checks++;
    if (obs_b !== 11'd0) begin n_errors++; $display("FAIL reset_b: got %h expected %h", obs_b, 11'd0); end
    release_reset();
  endtask

  task automatic test_lock_seq();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, i % 4);
      n_checks++;
      if (obs_a !== exp_a()) begin n_errors++; $display("FAIL lock_seq_a[%0d]: got %h expected %h", i, obs_a, exp_a()); end
      n_checks++;
      if (obs_b !== exp_b()) begin n_errors++; $display("FAIL lock_seq_b[%0d]: got %h expected %h", i, obs_b, exp_b()); end
      n_checks++;
      if (if_a.locked !== (i >= 4)) begin n_errors++; $display("FAIL lock_time[%0d]: locked=%b expected %b", i, if_a.locked, (i >= 4)); end
      n_checks++;
      if (if_a.wrap_pulse !== (i >= 8 && i % 4 == 0)) begin
        n_errors++; $display("FAIL wrap[%0d]: wrap=%b expected %b", i, if_a.wrap_pulse, (i >= 8 && i % 4 == 0));
      end
    end
  endtask

  task automatic test_skip();
    int seq[8] = '{0, 1, 3, 0, 1, 2, 3, 0};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, seq[i]);
      n_checks++;
      if (obs_a !== exp_a()) begin n_errors++; $display("FAIL skip_a[%0d]: got %h expected %h", i, obs_a, exp_a()); end
      n_checks++;
      if (obs_b !== exp_b()) begin n_errors++; $display("FAIL skip_b[%0d]: got %h expected %h", i, obs_b, exp_b()); end
      if (i == 2) begin
        n_checks++;
        if ({if_a.err_pulse, if_a.locked, if_a.err_count} !== {1'b1, 1'b0, 8'd1}) begin
          n_errors++; $display("FAIL skip_err: pulse/locked/count=%b/%b/%0d expected 1/0/1", if_a.err_pulse, if_a.locked, if_a.err_count);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (if_a.locked !== 1'b1) begin n_errors++; $display("FAIL skip_relock: locked=%b expected 1", if_a.locked); end
      end
    end
  endtask

  task automatic test_stuck();
    int seq[8] = '{1, 2, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, seq[i]);
      n_checks++;
      if (obs_a !== exp_a()) begin n_errors++; $display("FAIL stuck_a[%0d]: got %h expected %h", i, obs_a, exp_a()); end
      n_checks++;
      if (obs_b !== exp_b()) begin n_errors++; $display("FAIL stuck_b[%0d]: got %h expected %h", i, obs_b, exp_b()); end
      if (i == 2) begin
        n_checks++;
        if ({if_a.err_pulse, if_a.err_count, if_a.last_good} !== {1'b1, 8'd2, 4'd2}) begin
          n_errors++; $display("FAIL stuck_err: pulse/count/last_good=%b/%0d/%0d expected 1/2/2", if_a.err_pulse, if_a.err_count, if_a.last_good);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    int seq[7] = '{0, 5, 2, 3, 0, 1, 2};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, seq[i]);
      n_checks++;
      if (obs_a !== exp_a()) begin n_errors++; $display("FAIL oor_a[%0d]: got %h expected %h", i, obs_a, exp_a()); end
      n_checks++;
      if (obs_b !== exp_b()) begin n_errors++; $display("FAIL oor_b[%0d]: got %h expected %h", i, obs_b, exp_b()); end
      if (i == 1) begin
        n_checks++;
        if ({if_a.err_pulse, if_a.locked, if_a.last_good} !== {1'b1, 1'b0, 4'd0}) begin
          n_errors++; $display("FAIL oor_err: pulse/locked/last_good=%b/%b/%0d expected 1/0/0", if_a.err_pulse, if_a.locked, if_a.last_good);
        end
      end
    end
  endtask

  task automatic test_en_gap();
    cycle(1'b1, 3);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) cycle(1'b0, $urandom_range(0, 15));
      else cycle(1'b1, (m_prev + 1) % M);
      n_checks++;
      if (obs_a !== exp_a()) begin n_errors++; $display("FAIL en_gap_a[%0d]: got %h expected %h", i, obs_a, exp_a()); end
      n_checks++;
      if (obs_b !== exp_b()) begin n_errors++; $display("FAIL en_gap_b[%0d]: got %h expected %h", i, obs_b, exp_b()); end
      n_checks++;
      if ({if_a.locked, if_a.err_pulse} !== 2'b10) begin
        n_errors++; $display("FAIL en_gap_hold[%0d]: locked/err=%b/%b expected 1/0", i, if_a.locked, if_a.err_pulse);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset(1);
    release_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, i % 4);
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b1, m_prev);
      n_checks++;
      if (if_b.err_count !== 2'((k > 3) ? 3 : k)) begin
        n_errors++; $display("FAIL sat_b[%0d]: err_count=%0d expected %0d", k, if_b.err_count, (k > 3) ? 3 : k);
      end
      n_checks++;
      if (if_a.err_count !== 8'(k)) begin n_errors++; $display("FAIL sat_a[%0d]: err_count=%0d expected %0d", k, if_a.err_count, k); end
      for (int j = 0; j < L; j++) begin
        cycle(1'b1, (m_prev + 1) % M);
        n_checks++;
        if (obs_b !== exp_b()) begin n_errors++; $display("FAIL sat_relock_b[%0d.%0d]: got %h expected %h", k, j, obs_b, exp_b()); end
      end
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b1, (m_prev + 1) % M);
    do_reset(1);
    n_checks++;
    if ({st_a, if_a.locked, if_a.err_pulse, if_a.wrap_pulse, if_a.last_good, if_a.err_count} !== 17'd0) begin
      n_errors++; $display("FAIL mid_reset: got %h expected %h", obs_a, 17'd0);
    end
    release_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, (i + 2) % 4);
      n_checks++;
      if (obs_a !== exp_a()) begin n_errors++; $display("FAIL reacq_a[%0d]: got %h expected %h", i, obs_a, exp_a()); end
      n_checks++;
      if (if_a.locked !== (i >= 4)) begin n_errors++; $display("FAIL reacq_lock[%0d]: locked=%b expected %b", i, if_a.locked, (i >= 4)); end
    end
  endtask

  task automatic test_random();
    int v;
    bit e;
    do_reset(2);
    release_reset();
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 9) < 8);
      case ($urandom_range(0, 19))
        0:       v = $urandom_range(0, 15);
        1:       v = m_prev;
        2:       v = (m_prev + 2) % M;
        default: v = (m_prev + 1) % M;
      endcase
      cycle(e, v);
      n_checks++;
      if (obs_a !== exp_a()) begin n_errors++; $display("FAIL random_a[%0d]: got %h expected %h", i, obs_a, exp_a()); end
      n_checks++;
      if (obs_b !== exp_b()) begin n_errors++; $display("FAIL random_b[%0d]: got %h expected %h", i, obs_b, exp_b()); end
    end
  endtask

  // Sequencer and final report
  initial begin
    rst = 1'b1;
    if_a.en = 1'b0; if_a.count_in = '0;
    if_b.en = 1'b0; if_b.count_in = '0;
    model_reset();
    test_reset();
    test_lock_seq();
    test_skip();
    test_stuck();
    test_out_of_range();
    test_en_gap();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
